// File: rtl/uart_rx_parity.sv
// UART receiver: start bit, DATA_WIDTH data bits LSB-first, even parity bit, stop bit.
// The serial line is synchronized, then sampled once at mid-bit for every bit of the
// frame. RxData/valid_rx update at the mid-parity sample and frame_err updates at the
// mid-stop sample. Both hold their values until the next frame reaches the same point.
module uart_rx_parity #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  TxD,
  output logic [DATA_WIDTH-1:0] RxData,
  output logic                  valid_rx,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int IW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_reg, state_next;
  logic                    sync1_reg, sync2_reg;
  logic [CW-1:0]           cnt_reg;
  logic [IW-1:0]           idx_reg;
  logic [DATA_WIDTH-1:0]   shift_reg;

  logic line;
  logic half_hit, bit_hit;
  logic sample_data, sample_parity, sample_stop;

  assign line     = sync2_reg;
  assign half_hit = (cnt_reg == CW'(HALF - 1));
  assign bit_hit  = (cnt_reg == CW'(CPB - 1));

  // Two-flop synchronizer. It resets to the idle level so that reset cannot fake a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= TxD;
      sync2_reg <= sync1_reg;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic. START either confirms the start bit at mid-bit or rejects it as a glitch.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!line) state_next = START;
      START:   if (half_hit) state_next = line ? IDLE : DATA;
      DATA:    if (bit_hit && (idx_reg == IW'(DATA_WIDTH - 1))) state_next = PARITY;
      PARITY:  if (bit_hit) state_next = STOP;
      STOP:    if (bit_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: busy flag and the mid-bit sample strobes for each phase
  always_comb begin
    busy          = (state_reg != IDLE);
    sample_data   = (state_reg == DATA)   && bit_hit;
    sample_parity = (state_reg == PARITY) && bit_hit;
    sample_stop   = (state_reg == STOP)   && bit_hit;
  end

  // Bit-period counter. It restarts on every state change and after every full bit period.
  always_ff @(posedge clk) begin
    if (reset)
      cnt_reg <= '0;
    else if (state_reg == IDLE || state_next != state_reg || bit_hit)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_reg + CW'(1);
  end

  // Data bit index. It is cleared while the start bit is qualified.
  always_ff @(posedge clk) begin
    if (reset)
      idx_reg <= '0;
    else if (state_reg == START)
      idx_reg <= '0;
    else if (sample_data)
      idx_reg <= idx_reg + IW'(1);
  end

  // Each mid-bit sample is placed at its LSB-first bit position.
  always_ff @(posedge clk) begin
    if (reset)
      shift_reg <= '0;
    else if (sample_data)
      shift_reg[idx_reg] <= line;
  end

  // Result registers: word and parity verdict at mid-parity, framing verdict at mid-stop
  always_ff @(posedge clk) begin
    if (reset) begin
      RxData    <= '0;
      valid_rx  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (sample_parity) begin
        RxData   <= shift_reg;
        valid_rx <= ~(^shift_reg ^ line);
      end
      if (sample_stop)
        frame_err <= ~line;
    end
  end

endmodule

// File: tb/tb_uart_rx_parity.sv
// Testbench for uart_rx_parity. Frames are driven bit by bit and checked against a
// frame-level model: the expected word is the data sent, parity is good when the count
// of ones over the data bits and the parity bit is even, and a framing error is flagged
// when the stop bit is low.
module tb_uart_rx_parity;

  localparam int CLK_FREQ = 7_372_800;
  localparam int BAUD     = 115_200;
  localparam int CPB      = CLK_FREQ / BAUD;   // 64
  localparam int HALF     = CPB / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       TxD = 1'b1;
  logic [7:0] RxData;
  logic       valid_rx, frame_err, busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_data  = 8'h00;
  logic       exp_valid = 1'b0;

  uart_rx_parity #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .TxD(TxD),
    .RxData(RxData), .valid_rx(valid_rx), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Step n clock edges, then move 1 time unit past the edge for both driving and sampling.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ((($countones(d) + int'(p)) % 2) == 0);
  endfunction

  // Drive one frame. The word and parity verdict are checked a quarter into the stop bit,
  // and the framing verdict is checked at the end of the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop_bit, input string tag);
    TxD = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      TxD = d[i];
      tick(CPB);
    end
    TxD = p;
    tick(CPB);
    TxD = stop_bit;
    tick(CPB / 4);
    exp_data  = d;
    exp_valid = parity_ok(d, p);
    check_eq({tag, ".data"},  32'(RxData),   32'(exp_data));
    check_eq({tag, ".valid"}, 32'(valid_rx), 32'(exp_valid));
    tick(CPB - CPB / 4);
    check_eq({tag, ".ferr"},  32'(frame_err), 32'(!stop_bit));
    if (stop_bit) check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    $display("frame %s: data=%02h par=%0b stop=%0b -> RxData=%02h valid=%0b ferr=%0b",
             tag, d, p, stop_bit, RxData, valid_rx, frame_err);
  endtask

  initial begin
    logic [7:0] d;
    logic       p;

    // Reset after 10 idle cycles
    tick(10);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_eq("rst.data",  32'(RxData),    32'd0);
    check_eq("rst.valid", 32'(valid_rx),  32'd0);
    check_eq("rst.ferr",  32'(frame_err), 32'd0);
    check_eq("rst.busy",  32'(busy),      32'd0);
    tick(CPB);

    // Good parity, then wrong parity
    send_frame(8'hA5, 1'b0, 1'b1, "a5");
    send_frame(8'h01, 1'b0, 1'b1, "01_badpar");

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b0, 1'b1, "00_b2b");
    send_frame(8'hFF, 1'b0, 1'b1, "ff_b2b");
    tick(CPB);

    // A short low glitch is rejected at the start-bit midpoint and leaves the outputs alone.
    TxD = 1'b0;
    tick(HALF / 2);
    TxD = 1'b1;
    check_eq("glitch.busy_hi", 32'(busy), 32'd1);
    tick(HALF + 8);
    check_eq("glitch.busy_lo", 32'(busy),     32'd0);
    check_eq("glitch.data",    32'(RxData),   32'(exp_data));
    check_eq("glitch.valid",   32'(valid_rx), 32'(exp_valid));
    tick(CPB);
    send_frame(8'h3C, 1'b0, 1'b1, "3c");

    // Stop bit held low gives a framing error. The line then idles long enough for any
    // frame that the receiver starts in response to finish.
    send_frame(8'h81, 1'b0, 1'b0, "81_badstop");
    TxD = 1'b1;
    tick(13 * CPB);

    // Reset in the middle of the data bits
    TxD = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      TxD = 1'(8'h5A >> i);
      tick(CPB);
    end
    tick(CPB / 3);
    reset = 1'b1;
    TxD   = 1'b1;
    tick(1);
    reset = 1'b0;
    check_eq("midrst.data",  32'(RxData),    32'd0);
    check_eq("midrst.valid", 32'(valid_rx),  32'd0);
    check_eq("midrst.ferr",  32'(frame_err), 32'd0);
    check_eq("midrst.busy",  32'(busy),      32'd0);
    tick(2 * CPB);
    send_frame(8'h5A, 1'b0, 1'b1, "5a");

    // Random words back to back. The parity bit is wrong about one time in four.
    for (int k = 0; k < 10; k++) begin
      d = 8'($urandom_range(0, 255));
      p = ^d;
      if ($urandom_range(0, 3) == 0) p = ~p;
      send_frame(d, p, 1'b1, $sformatf("rnd%0d", k));
    end
    tick(CPB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
